// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and stream widths.
package imem_loader_pkg;

   localparam int unsigned HdrWidth     = 16;
   localparam int unsigned WordWidth    = 32;
   localparam int unsigned BytesPerWord = WordWidth / 8;

   typedef enum logic [2:0] {
      StLenLo,
      StLenHi,
      StData,
      StWrite,
      StCheck,
      StDone,
      StError
   } state_e;

endpackage

// File: rtl/byte_assembler.sv
// Packs a byte stream into little-endian 32-bit words; word_ready pulses in the cycle the
// fourth byte of a word is presented, with the completed word visible on word.
module byte_assembler
   import imem_loader_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 byte_valid,
   input  logic [7:0]           byte_data,
   output logic [WordWidth-1:0] word,
   output logic                 word_ready
);

   logic [1:0]           cnt_q, cnt_d;
   logic [WordWidth-1:0] shift_q, shift_d;

   // Bytes enter at the top and shift down, so the first byte ends up in bits [7:0].
   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (clear) begin
         cnt_d   = 2'd0;
         shift_d = '0;
      end else if (byte_valid) begin
         cnt_d   = cnt_q + 2'd1;
         shift_d = {byte_data, shift_q[WordWidth-1:8]};
      end
   end

   assign word       = {byte_data, shift_q[WordWidth-1:8]};
   assign word_ready = byte_valid && !clear && (cnt_q == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= 2'd0;
         shift_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes it into instruction memory,
// holding the core in reset until done. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR = 64'd0,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   output logic                 rx_ready,
   output logic                 imem_we,
   output logic [63:0]          imem_addr,
   output logic [WordWidth-1:0] imem_wdata,
   output logic                 cpu_reset,
   output logic                 load_done,
   output logic                 load_error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_e EndState = StCheck;
`else
   localparam state_e EndState = StDone;
`endif

   state_e               state_q, state_d;
   logic [HdrWidth-1:0]  len_q, len_d;
   logic [7:0]           len_lo_q, len_lo_d;
   logic [HdrWidth-1:0]  word_idx_q, word_idx_d;
   logic [63:0]          addr_q, addr_d;
   logic [WordWidth-1:0] wdata_q, wdata_d;
   logic [HdrWidth-1:0]  hdr_n;
   logic                 accept;
   logic                 restart;
   logic                 asm_valid;
   logic                 word_ready;
   logic [WordWidth-1:0] asm_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]           csum_q, csum_d;
`endif

   assign rx_ready  = !reset && (state_q inside {StLenLo, StLenHi, StData, StCheck});
   assign accept    = rx_valid && rx_ready;
   assign restart   = start && (state_q inside {StDone, StError});
   assign asm_valid = accept && (state_q == StData);
   assign hdr_n     = {rx_data, len_lo_q};

   byte_assembler u_byte_assembler (
      .clk        (clk),
      .reset      (reset),
      .clear      (restart),
      .byte_valid (asm_valid),
      .byte_data  (rx_data),
      .word       (asm_word),
      .word_ready (word_ready)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      len_lo_d   = len_lo_q;
      word_idx_d = word_idx_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d     = asm_valid ? (csum_q ^ rx_data) : csum_q;
`endif
      unique case (state_q)
         StLenLo: begin
            if (accept) begin
               len_lo_d = rx_data;
               state_d  = StLenHi;
            end
         end
         StLenHi: begin
            if (accept) begin
               len_d = hdr_n;
               if (32'(hdr_n) > MAX_WORDS) state_d = StError;
               else if (hdr_n == '0)       state_d = EndState;
               else                        state_d = StData;
            end
         end
         StData: begin
            if (word_ready) begin
               addr_d  = BASE_ADDR + {46'd0, word_idx_q, 2'b00};
               wdata_d = asm_word;
               state_d = StWrite;
            end
         end
         StWrite: begin
            word_idx_d = word_idx_q + 16'd1;
            state_d    = (word_idx_d < len_q) ? StData : EndState;
         end
         StCheck: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept) state_d = (rx_data == csum_q) ? StDone : StError;
`else
            state_d = StError;
`endif
         end
         StDone, StError: begin
            if (restart) begin
               state_d    = StLenLo;
               len_d      = '0;
               len_lo_d   = '0;
               word_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d     = '0;
`endif
            end
         end
         default: state_d = StLenLo;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StLenLo;
         len_q      <= '0;
         len_lo_q   <= '0;
         word_idx_q <= '0;
         addr_q     <= BASE_ADDR;
         wdata_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         len_lo_q   <= len_lo_d;
         word_idx_q <= word_idx_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign imem_we    = (state_q == StWrite);
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_reset  = (state_q != StDone);
   assign load_done  = (state_q == StDone);
   assign load_error = (state_q == StError);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes and end status are
// derived from the stream format (count header, little-endian words, optional XOR byte).
module tb_imem_loader;

   localparam logic [63:0] Base = 64'h100;
   localparam int unsigned MaxW = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready;
   logic        imem_we;
   logic [63:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic        load_done;
   logic        load_error;

   int checks = 0;
   int failures = 0;

   imem_loader #(
      .BASE_ADDR (Base),
      .MAX_WORDS (MaxW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clk = ~clk;

   // Write monitor: records every strobed write and flags strobes lasting more than a cycle.
   logic [63:0] obs_addr[$];
   logic [31:0] obs_data[$];
   int          we_long = 0;
   logic        prev_we = 1'b0;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         obs_addr.push_back(imem_addr);
         obs_data.push_back(imem_wdata);
         if (prev_we) we_long++;
      end
      prev_we <= imem_we;
   end

   function automatic int gap_of(input int mode);
      if (mode == 0) return 0;
      if (mode == 1) return 1;
      return int'($urandom_range(3));
   endfunction

   // Present one byte, with idle cycles (garbage data, random start) before it.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit acc = 1'b0;
      repeat (gap) begin
         @(negedge clk);
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
         start    = 1'($urandom_range(1));
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      start    = 1'($urandom_range(1));
      for (int t = 0; t < 32; t++) begin
         logic rdy;
         #1 rdy = rx_ready;
         @(posedge clk);
         if (rdy === 1'b1) begin
            acc = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!acc) begin
         failures++;
         $display("FAIL byte_accept: byte %h not accepted, got timeout, required accept", b);
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      rx_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic do_start(input string name);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if ({load_done, load_error, rx_ready, cpu_reset} !== 4'b0011) begin
         failures++;
         $display("FAIL %s_restart: done/err/ready/cpu_reset=%b required 0011", name,
                  {load_done, load_error, rx_ready, cpu_reset});
      end
   endtask

   task automatic run_load(input string name, input logic [15:0] n, input logic [31:0] words[$],
                           input int gmode, input bit corrupt);
      int         base_idx = obs_addr.size();
      int         long0 = we_long;
      logic [7:0] csum = 8'h00;
      bit         exp_err = (32'(n) > MaxW);
      int         exp_writes = exp_err ? 0 : int'(n);
      int         got;
      bit         ended = 1'b0;
      send_byte(n[7:0], gap_of(gmode));
      send_byte(n[15:8], gap_of(gmode));
      if (!exp_err) begin
         for (int i = 0; i < int'(n); i++) begin
            for (int k = 0; k < 4; k++) begin
               logic [7:0] b = words[i][8*k +: 8];
               csum ^= b;
               send_byte(b, gap_of(gmode));
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (corrupt) begin
            send_byte(csum ^ 8'($urandom_range(255, 1)), gap_of(gmode));
            exp_err = 1'b1;
         end else begin
            send_byte(csum, gap_of(gmode));
         end
`endif
      end
      go_idle();
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         #1;
         if (load_done === 1'b1 || load_error === 1'b1) begin
            ended = 1'b1;
            break;
         end
      end
      checks++;
      if (!ended) begin
         failures++;
         $display("FAIL %s_end: timeout waiting for load_done/load_error, required an end state",
                  name);
      end
      checks++;
      if ({load_done, load_error, cpu_reset, rx_ready} !== {!exp_err, exp_err, exp_err, 1'b0}) begin
         failures++;
         $display("FAIL %s_status: done/err/cpu_reset/ready=%b required %b", name,
                  {load_done, load_error, cpu_reset, rx_ready},
                  {!exp_err, exp_err, exp_err, 1'b0});
      end
      got = obs_addr.size() - base_idx;
      checks++;
      if (got != exp_writes) begin
         failures++;
         $display("FAIL %s_write_count: got %0d writes required %0d", name, got, exp_writes);
      end
      for (int i = 0; i < exp_writes && i < got; i++) begin
         logic [63:0] ea = Base + 64'(4 * i);
         checks++;
         if (obs_addr[base_idx+i] !== ea || obs_data[base_idx+i] !== words[i]) begin
            failures++;
            $display("FAIL %s_write%0d: addr=%h data=%h required addr=%h data=%h", name, i,
                     obs_addr[base_idx+i], obs_data[base_idx+i], ea, words[i]);
         end
      end
      if (exp_writes > 0) begin
         checks++;
         if (imem_addr !== Base + 64'(4 * (exp_writes - 1)) ||
             imem_wdata !== words[exp_writes-1]) begin
            failures++;
            $display("FAIL %s_hold: addr=%h data=%h required last written values", name,
                     imem_addr, imem_wdata);
         end
      end
      checks++;
      if (we_long != long0) begin
         failures++;
         $display("FAIL %s_we_width: imem_we held %0d extra cycles required 0", name,
                  we_long - long0);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset    = 1'b1;
      start    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({rx_ready, imem_we, cpu_reset, load_done, load_error} !== 5'b00100) begin
         failures++;
         $display("FAIL reset_outputs: ready/we/cpu_reset/done/err=%b required 00100",
                  {rx_ready, imem_we, cpu_reset, load_done, load_error});
      end
      checks++;
      if (imem_addr !== Base || imem_wdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_regs: addr=%h data=%h required %h 0", imem_addr, imem_wdata, Base);
      end
      reset    = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (rx_ready !== 1'b1 || cpu_reset !== 1'b1) begin
         failures++;
         $display("FAIL reset_release: ready=%b cpu_reset=%b required 1 1", rx_ready, cpu_reset);
      end
   endtask

   task automatic test_single_word();
      logic [31:0] w[$];
      w.push_back(32'h00500093);
      run_load("single", 16'd1, w, 0, 1'b0);
      do_start("single");
   endtask

   task automatic test_two_words();
      logic [31:0] w[$];
      w.push_back(32'h00500093);
      w.push_back(32'h00A00113);
      run_load("two", 16'd2, w, 0, 1'b0);
      do_start("two");
   endtask

   task automatic test_bounds();
      logic [31:0] w[$];
      logic [31:0] none[$];
      for (int i = 0; i < int'(MaxW); i++) w.push_back($urandom);
      run_load("zero", 16'd0, none, 2, 1'b0);
      do_start("zero");
      run_load("max", 16'(MaxW), w, 2, 1'b0);
      do_start("max");
      run_load("over", 16'(MaxW + 1), none, 0, 1'b0);
      do_start("over");
      run_load("n257", 16'd257, none, 0, 1'b0);
      do_start("n257");
   endtask

   task automatic test_toggle();
      logic [31:0] w[$];
      for (int i = 0; i < 3; i++) w.push_back($urandom);
      run_load("toggle", 16'd3, w, 1, 1'b0);
      do_start("toggle");
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         logic [31:0] w[$];
         logic [15:0] n = 16'($urandom_range(MaxW, 1));
         for (int i = 0; i < int'(n); i++) w.push_back($urandom);
         run_load("random", n, w, 2, 1'b0);
         do_start("random");
      end
   endtask

   task automatic test_reset_midload();
      logic [31:0] w[$];
      int base_idx = obs_addr.size();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h01, 0);
      @(negedge clk);
      reset    = 1'b1;
      rx_valid = 1'b0;
      start    = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (obs_addr.size() != base_idx || rx_ready !== 1'b1 || imem_addr !== Base) begin
         failures++;
         $display("FAIL midload_reset: writes=%0d ready=%b addr=%h required 0 1 %h",
                  obs_addr.size() - base_idx, rx_ready, imem_addr, Base);
      end
      w.push_back(32'h00500093);
      run_load("reload", 16'd1, w, 0, 1'b0);
      do_start("reload");
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [31:0] w[$];
      w.push_back(32'h00500093);
      run_load("csum_bad", 16'd1, w, 0, 1'b1);
      do_start("csum_bad");
      run_load("csum_good", 16'd1, w, 2, 1'b0);
      do_start("csum_good");
   endtask
`endif

   initial begin
      test_reset();
      test_single_word();
      test_two_words();
      test_bounds();
      test_toggle();
      test_random();
      test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
